// File: rtl/reg_dump_reader_pkg.sv
// Shared constants and state encoding for the register dump reader,
// the register file and the read-port mux.
package reg_dump_reader_pkg;

   localparam int DATA_W   = 16;
   localparam int NUM_REGS = 8;
   localparam int ADDR_W   = $clog2(NUM_REGS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      SEND = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/reg_dump_idx_ctr.sv
// Wrapping register index counter with a captured end index and an
// equals-last compare. NUM_REGS is a power of two, so the natural
// ADDR_W-bit overflow provides the modulo wrap.
module reg_dump_idx_ctr
   import reg_dump_reader_pkg::*;
(
   input  logic              clk,
   input  logic              rst_b,
   input  logic              load,
   input  logic              inc,
   input  logic [ADDR_W-1:0] first,
   input  logic [ADDR_W-1:0] last,
   output logic [ADDR_W-1:0] idx,
   output logic              at_last
);

   logic [ADDR_W-1:0] idx_reg;
   logic [ADDR_W-1:0] last_reg;

   // Capture the range on load, step the index on increment.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         idx_reg  <= '0;
         last_reg <= '0;
      end else if (load) begin
         idx_reg  <= first;
         last_reg <= last;
      end else if (inc) begin
         idx_reg  <= idx_reg + 1'b1;
      end
   end

   assign idx     = idx_reg;
   assign at_last = (idx_reg == last_reg);

endmodule

// File: rtl/reg_dump_reader.sv
// Walks an inclusive register range over the shared read port and
// streams each word out on a valid/ready handshake.
module reg_dump_reader
   import reg_dump_reader_pkg::*;
(
   input  logic              clk,
   input  logic              rst_b,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] first,
   input  logic [ADDR_W-1:0] last,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_idx,
   output logic              busy,
   output logic              done
);

   state_t            state_reg;
   state_t            state_next;
   logic [ADDR_W-1:0] idx;
   logic              at_last;
   logic              ctr_load;
   logic              ctr_inc;
   logic              accept;
   logic [DATA_W-1:0] out_data_reg;
   logic [ADDR_W-1:0] out_idx_reg;

   // A handshake that coincides with abort still completes the word, but
   // the walk stops there, so the index is not advanced.
   assign accept   = (state_reg == SEND) && out_ready;
   assign ctr_load = (state_reg == IDLE) && start;
   assign ctr_inc  = accept && !abort && !at_last;

   reg_dump_idx_ctr u_idx_ctr (
      .clk     (clk),
      .rst_b   (rst_b),
      .load    (ctr_load),
      .inc     (ctr_inc),
      .first   (first),
      .last    (last),
      .idx     (idx),
      .at_last (at_last)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state decode; abort has priority over the handshake.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (start) state_next = READ;
         end
         READ: begin
            state_next = abort ? IDLE : SEND;
         end
         SEND: begin
            if (abort)          state_next = IDLE;
            else if (out_ready) state_next = at_last ? DONE : READ;
         end
         DONE: begin
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Capture the read-port word (write bypass included) during READ and
   // hold it through any SEND stall.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         out_data_reg <= '0;
         out_idx_reg  <= '0;
      end else if (state_reg == READ) begin
         out_data_reg <= rd_data;
         out_idx_reg  <= idx;
      end
   end

   assign rd_en     = (state_reg == READ);
   assign rd_addr   = idx;
   assign out_valid = (state_reg == SEND);
   assign out_data  = out_data_reg;
   assign out_idx   = out_idx_reg;
   assign busy      = (state_reg != IDLE);
   assign done      = (state_reg == DONE);

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench: a small register-file model with write bypass feeds the
// read port; expected words go into a scoreboard queue when a dump is
// started and are popped as the DUT hands them over.
module tb_reg_dump_reader;

   logic        clk;
   logic        rst_b;
   logic        start;
   logic        abort;
   logic [2:0]  first;
   logic [2:0]  last;
   logic        rd_en;
   logic [2:0]  rd_addr;
   logic [15:0] rd_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [2:0]  out_idx;
   logic        busy;
   logic        done;

   logic [15:0] regs [8];
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [15:0] wr_data;

   typedef struct packed {
      logic [2:0]  idx;
      logic [15:0] data;
   } exp_t;

   exp_t exp_q [$];
   int   checks;
   int   failures;
   int   done_cnt;
   int   cyc;

   reg_dump_reader dut (
      .clk       (clk),
      .rst_b     (rst_b),
      .start     (start),
      .abort     (abort),
      .first     (first),
      .last      (last),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file read port with same-cycle write bypass.
   assign rd_data = (wr_en && (wr_addr == rd_addr)) ? wr_data : regs[rd_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One clock: observe the handshake at the falling edge, commit any
   // register write just after the rising edge.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
         $display("xfer idx=%0d data=%h", out_idx, out_data);
         if (exp_q.size() == 0) begin
            chk("unexpected_word", 32'(out_idx), 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("xfer_idx", 32'(out_idx), 32'(e.idx));
            chk("xfer_data", 32'(out_data), 32'(e.data));
         end
      end
      @(posedge clk);
      #1;
      if (wr_en) regs[wr_addr] = wr_data;
   endtask

   task automatic push_range(input logic [2:0] f, input logic [2:0] l);
      logic [2:0] i;
      exp_t       e;
      i = f;
      forever begin
         e.idx  = i;
         e.data = regs[i];
         exp_q.push_back(e);
         if (i == l) break;
         i = i + 3'd1;
      end
   endtask

   task automatic kick(input logic [2:0] f, input logic [2:0] l);
      first = f;
      last  = l;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int max_cyc);
      int   d0;
      logic seen;
      d0   = done_cnt;
      seen = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         tick();
         if (done_cnt != d0) begin
            seen = 1'b1;
            break;
         end
      end
      chk("done_within_bound", 32'(seen), 32'd1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk(tag, {15'd0, rd_en, rd_addr, out_valid, busy, done, out_idx, 1'b0, out_data[7:0]} | 32'(out_data), 32'd0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      done_cnt = 0;
      rst_b    = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      first    = 3'd0;
      last     = 3'd0;
      out_ready = 1'b0;
      wr_en    = 1'b0;
      wr_addr  = 3'd0;
      wr_data  = 16'h0;
      for (int i = 0; i < 8; i++) regs[i] = 16'(16'h1000 + i);

      // Reset state
      #2;
      chk_all_zero("reset_outputs");
      @(posedge clk);
      #1;
      rst_b = 1'b1;
      tick();
      chk("idle_busy", 32'(busy), 32'd0);

      // Basic range 2..4 with per-cycle timing
      regs[2] = 16'h1234;
      regs[3] = 16'hABCD;
      regs[4] = 16'h0F0F;
      out_ready = 1'b1;
      push_range(3'd2, 3'd4);
      kick(3'd2, 3'd4);
      cyc = 1;
      chk("c1_rd_en", 32'(rd_en), 32'd1);
      chk("c1_rd_addr", 32'(rd_addr), 32'd2);
      for (int c = 2; c <= 8; c++) begin
         tick();
         cyc = c;
         chk("basic_valid", 32'(out_valid), 32'((c == 2) || (c == 4) || (c == 6)));
         chk("basic_done", 32'(done), 32'(c == 7));
         chk("basic_busy", 32'(busy), 32'(c <= 7));
      end
      chk("basic_queue_empty", 32'(exp_q.size()), 32'd0);
      chk("basic_done_cnt", 32'(done_cnt), 32'd1);

      // Wrapping range 6..1
      regs[6] = 16'h6666;
      regs[7] = 16'h7777;
      regs[0] = 16'hA0A0;
      regs[1] = 16'hB1B1;
      push_range(3'd6, 3'd1);
      chk("wrap_pushed", 32'(exp_q.size()), 32'd4);
      kick(3'd6, 3'd1);
      wait_done(20);
      chk("wrap_queue_empty", 32'(exp_q.size()), 32'd0);
      tick();

      // Backpressure on a single-word dump
      regs[5] = 16'h5555;
      out_ready = 1'b0;
      push_range(3'd5, 3'd5);
      kick(3'd5, 3'd5);
      tick();
      for (int i = 0; i < 10; i++) begin
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_data", 32'(out_data), 32'h5555);
         chk("stall_idx", 32'(out_idx), 32'd5);
         tick();
      end
      out_ready = 1'b1;
      tick();
      chk("stall_done", 32'(done), 32'd1);
      tick();
      chk("stall_idle", 32'(busy), 32'd0);
      chk("stall_queue_empty", 32'(exp_q.size()), 32'd0);

      // Same-cycle write bypass
      regs[3] = 16'h1111;
      kick(3'd3, 3'd3);
      chk("bypass_rd_en", 32'(rd_en), 32'd1);
      wr_en   = 1'b1;
      wr_addr = 3'd3;
      wr_data = 16'hBEEF;
      exp_q.push_back('{idx: 3'd3, data: 16'hBEEF});
      tick();
      wr_en = 1'b0;
      wait_done(10);
      chk("bypass_queue_empty", 32'(exp_q.size()), 32'd0);
      tick();

      // Abort during SEND of idx 2
      for (int i = 0; i < 8; i++) regs[i] = 16'(16'hC000 + 16'(i * 17));
      push_range(3'd0, 3'd1);
      cyc = done_cnt;
      kick(3'd0, 3'd7);
      for (int i = 0; i < 5; i++) tick();
      chk("abort_at_idx2", 32'({out_valid, out_idx}), 32'({1'b1, 3'd2}));
      out_ready = 1'b0;
      abort     = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_valid_low", 32'(out_valid), 32'd0);
      chk("abort_idle", 32'(busy), 32'd0);
      tick();
      tick();
      chk("abort_no_done", 32'(done_cnt), 32'(cyc));
      chk("abort_queue_empty", 32'(exp_q.size()), 32'd0);
      out_ready = 1'b1;
      push_range(3'd0, 3'd0);
      kick(3'd0, 3'd0);
      wait_done(10);
      chk("restart_queue_empty", 32'(exp_q.size()), 32'd0);
      tick();

      // Start while busy is ignored
      push_range(3'd1, 3'd2);
      kick(3'd1, 3'd2);
      tick();
      first = 3'd6;
      last  = 3'd6;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(10);
      chk("busy_start_queue_empty", 32'(exp_q.size()), 32'd0);
      tick();
      chk("busy_start_idle", 32'(busy), 32'd0);

      // Asynchronous reset during SEND
      cyc = done_cnt;
      kick(3'd0, 3'd7);
      tick();
      chk("prereset_valid", 32'(out_valid), 32'd1);
      #2;
      rst_b = 1'b0;
      #1;
      chk_all_zero("async_reset_outputs");
      tick();
      rst_b = 1'b1;
      tick();
      chk("reset_no_done", 32'(done_cnt), 32'(cyc));
      chk("reset_idle", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
Read-side counterpart to the 16-bit general-purpose registers (R0..R7). It walks an inclusive register range and fetches each word over the register-file read port. Each word is streamed out over a valid/ready handshake to the debug/trace path. It sits beside the register file and shares the read port with the datapath, which is granted via rd_en.

Parameters:
DATA_W, 16, register word width
NUM_REGS, 8, number of registers in the file (power of two)
ADDR_W, 3, log2(NUM_REGS)

Ports:
clk  input  1  system clock, rising edge
rst_b  input  1  asynchronous active-low reset
start  input  1  begin dump; sampled only in IDLE
abort  input  1  cancel dump in progress
first  input  ADDR_W  first register index, sampled with start
last  input  ADDR_W  last register index (inclusive), sampled with start
rd_en  output  1  read-port request, high only in READ
rd_addr  output  ADDR_W  register index being read
rd_data  input  DATA_W  combinational read data (includes same-cycle write bypass)
out_valid  output  1  out_data/out_idx valid
out_ready  input  1  consumer accepts word
out_data  output  DATA_W  captured register value
out_idx  output  ADDR_W  index of out_data
busy  output  1  high in READ, SEND, DONE
done  output  1  one-cycle pulse after last word accepted

Behaviour:
- Reset (rst_b=0, asynchronous): state=IDLE; all outputs 0; internal idx and last_q cleared.
- States are IDLE, READ, SEND, DONE. All outputs are registered or decoded from state only, with no combinational path from inputs to outputs.
- IDLE:
  - start=1: latch idx<=first, last_q<=last; next state READ.
  - abort in IDLE has no effect.
- READ (one cycle):
  - rd_en=1, rd_addr=idx.
  - At the clock edge: out_data<=rd_data, out_idx<=idx; next state SEND.
  - A register write in the same cycle is captured with its new value, because the port bypasses writes.
- SEND:
  - out_valid=1. out_data and out_idx are held stable while out_ready=0, for an unbounded stall.
  - On out_valid&&out_ready with idx==last_q: next state DONE.
  - On out_valid&&out_ready otherwise: idx<=(idx+1) mod NUM_REGS; next state READ.
- DONE (one cycle): done=1, busy=1; next state IDLE.
- Latency and throughput:
  - start to first out_valid is 2 cycles.
  - Steady state is one word per 2 cycles with out_ready tied high.
- Range rules:
  - first==last dumps exactly 1 word.
  - last<first wraps through NUM_REGS-1 to 0, giving (last-first+NUM_REGS) mod NUM_REGS + 1 words.
  - A full 8-word dump uses first=last+1 mod 8.
- abort in READ/SEND: next state IDLE and out_valid drops next cycle. A word not yet handshaken is discarded, and done is not pulsed.
- If abort and an accepting handshake coincide, abort wins. That word counts as delivered, but no done is issued.
- start while busy is ignored. Changes to first/last after capture are ignored.
- Asynchronous reset mid-dump returns to IDLE immediately, with no done pulse.

Decomposition:
- A shared package holds:
  - the state encoding typedef (IDLE=2'd0, READ=2'd1, SEND=2'd2, DONE=2'd3);
  - the DATA_W/NUM_REGS/ADDR_W constants also used by the register file and read-port mux.
- One natural sub-module is reg_dump_idx_ctr: a wrapping ADDR_W-bit index counter with load, increment-enable and an equals-last compare. The FSM and output capture stay in the top.

Test Plan:
- Preload R2=16'h1234, R3=16'hABCD, R4=16'h0F0F; start with first=2, last=4 and out_ready=1 → words (2,1234),(3,ABCD),(4,0F0F) at cycles 2, 4 and 6 after start; done pulses at cycle 7; busy low afterwards.
- Wrap range first=6, last=1 with R6..R1 distinct → 4 words with idx 6,7,0,1 in order, then done.
- Backpressure: first=last=5, R5=16'h5555, out_ready=0 for 10 cycles then 1 → out_valid high and out_data=5555 stable for all 10 cycles; single handshake; done the next cycle.
- Same-cycle write: a datapath write of R3<=16'hBEEF in the READ cycle for idx 3 → out_data=BEEF.
- Abort mid-dump: range 0..7 with abort during the SEND of idx 2 → out_valid low next cycle; no done; idle; a new start with first=last=0 works normally.
- Reset: rst_b asserted during SEND → all outputs 0 asynchronously; start ignored while busy, verified by pulsing start in SEND with a different first, which leaves the sequence unchanged.
